// File: rtl/par_rcv_pkg.sv
// rtl/par_rcv_pkg.sv - shared parameters and control bundle for the parallel-interface receiver
package par_rcv_pkg;

  // Payload width; the FIFO word carries pkt_end above the payload at bit DSIZE.
  localparam int DSIZE_DEF = 32;
  // Width of the beat counter and of pkt_len.
  localparam int LSIZE_DEF = 8;

  // Datapath steering produced by the occupancy FSM each cycle.
  typedef struct packed {
    logic load_out;   // FIFO head word -> output reg
    logic load_skid;  // FIFO head word -> skid reg
    logic shift;      // skid reg -> output reg
  } rcv_ctl_t;

endpackage

// File: rtl/par_rcv_fsm.sv
// rtl/par_rcv_fsm.sv - occupancy FSM of the two-entry skid stage (rcv_fsm)
module rcv_fsm
  import par_rcv_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     rempty,
  input  logic     dready,
  output logic     r_en,
  output logic     dvalid,
  output rcv_ctl_t ctl
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state;
  logic   pop;
  logic   take;

  // Pop only while a slot is free; gated by reset so no word is consumed during reset.
  assign r_en   = rst_n & ~rempty & (state != FULL);
  assign dvalid = (state != EMPTY);
  assign pop    = r_en;
  assign take   = dvalid & dready;

  // Steer the incoming word to the output reg when it is (or is becoming) free, else to the skid reg.
  always_comb begin
    ctl           = '0;
    ctl.load_out  = pop & ((state == EMPTY) | take);
    ctl.load_skid = pop & (state == HALF) & ~take;
    ctl.shift     = (state == FULL) & take;
  end

  // Track how many words are buffered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: if (pop) state <= HALF;
        HALF: begin
          if (pop && !take)      state <= FULL;
          else if (take && !pop) state <= EMPTY;
        end
        FULL:    if (take) state <= HALF;
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/par_rcv.sv
// rtl/par_rcv.sv - FIFO read-side receiver with skid buffer and packet length reporting
module par_rcv
  import par_rcv_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int LSIZE = LSIZE_DEF
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rempty,
  input  logic [DSIZE:0]   rdata,
  output logic             r_en,
  output logic [DSIZE-1:0] dout,
  output logic             dlast,
  output logic             dvalid,
  input  logic             dready,
  output logic [LSIZE-1:0] pkt_len,
  output logic             pkt_done,
  output logic             len_ovf
);

  localparam int               PKT_END = DSIZE;
  localparam logic [LSIZE-1:0] CNT_MAX = '1;
  localparam logic [LSIZE-1:0] ONE     = LSIZE'(1);

  rcv_ctl_t         ctl;
  logic [DSIZE:0]   skid;
  logic [LSIZE-1:0] cnt;
  logic             take;

  assign take = dvalid & dready;

  rcv_fsm u_fsm (
    .clk    (rclk),
    .rst_n  (rrst_n),
    .rempty (rempty),
    .dready (dready),
    .r_en   (r_en),
    .dvalid (dvalid),
    .ctl    (ctl)
  );

  // Output and skid registers; the output reg holds while stalled because no control fires.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      dout  <= '0;
      dlast <= 1'b0;
      skid  <= '0;
    end else begin
      if (ctl.load_out) begin
        dout  <= rdata[DSIZE-1:0];
        dlast <= rdata[PKT_END];
      end else if (ctl.shift) begin
        dout  <= skid[DSIZE-1:0];
        dlast <= skid[PKT_END];
      end
      if (ctl.load_skid) skid <= rdata;
    end
  end

  // Saturating beat counter; hitting the ceiling on a non-last beat means the packet is too long.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      cnt      <= '0;
      pkt_len  <= '0;
      pkt_done <= 1'b0;
      len_ovf  <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      if (take) begin
        if (dlast) begin
          pkt_len  <= (cnt == CNT_MAX) ? CNT_MAX : cnt + ONE;
          pkt_done <= 1'b1;
          cnt      <= '0;
        end else if (cnt != CNT_MAX) begin
          cnt <= cnt + ONE;
          if (cnt == CNT_MAX - ONE) len_ovf <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_par_rcv.sv
// tb/tb_par_rcv.sv - self-checking bench for par_rcv against a queue-based reference model
module tb_par_rcv;

  localparam int DW = 32;
  localparam int LW = 4;

  logic          rclk;
  logic          rrst_n;
  logic          rempty;
  logic [DW:0]   rdata;
  logic          r_en;
  logic [DW-1:0] dout;
  logic          dlast;
  logic          dvalid;
  logic          dready;
  logic [LW-1:0] pkt_len;
  logic          pkt_done;
  logic          len_ovf;

  par_rcv #(.DSIZE(DW), .LSIZE(LW)) dut (
    .rclk     (rclk),
    .rrst_n   (rrst_n),
    .rempty   (rempty),
    .rdata    (rdata),
    .r_en     (r_en),
    .dout     (dout),
    .dlast    (dlast),
    .dvalid   (dvalid),
    .dready   (dready),
    .pkt_len  (pkt_len),
    .pkt_done (pkt_done),
    .len_ovf  (len_ovf)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  int          total = 0;
  int          bad   = 0;
  logic [DW:0] fifo_q[$];
  logic [DW:0] buf_q[$];
  int          beats;
  logic [LW-1:0] exp_len;
  logic        exp_done;
  logic        exp_ovf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] d, input logic l);
    fifo_q.push_back({l, d});
  endtask

  task automatic model_reset();
    buf_q.delete();
    beats    = 0;
    exp_len  = '0;
    exp_done = 1'b0;
    exp_ovf  = 1'b0;
  endtask

  // One clock cycle: drive at the falling edge, check, then advance the model over the rising edge.
  task automatic cyc(input logic rdy);
    logic        pop;
    logic        take;
    logic [DW:0] head;
    int          n;
    dready = rdy;
    rempty = (fifo_q.size() == 0);
    rdata  = rempty ? '0 : fifo_q[0];
    #1;
    pop  = (fifo_q.size() != 0) && (buf_q.size() < 2);
    take = (buf_q.size() != 0) && rdy;
    chk("dvalid", dvalid, buf_q.size() != 0);
    chk("r_en", r_en, pop);
    if (buf_q.size() != 0) begin
      head = buf_q[0];
      chk("dout", dout, head[DW-1:0]);
      chk("dlast", dlast, head[DW]);
    end
    chk("pkt_done", pkt_done, exp_done);
    chk("pkt_len", pkt_len, exp_len);
    chk("len_ovf", len_ovf, exp_ovf);
    @(posedge rclk);
    exp_done = 1'b0;
    if (take) begin
      head = buf_q.pop_front();
      beats++;
      if (head[DW]) begin
        n        = (beats > 15) ? 15 : beats;
        exp_len  = LW'(n);
        exp_done = 1'b1;
        beats    = 0;
      end else if (beats >= 15) begin
        exp_ovf = 1'b1;
      end
    end
    if (pop) buf_q.push_back(fifo_q.pop_front());
    @(negedge rclk);
  endtask

  initial begin
    rrst_n = 1'b0;
    rempty = 1'b1;
    rdata  = '0;
    dready = 1'b0;
    model_reset();

    // Reset state
    @(negedge rclk);
    #1;
    chk("rst_dvalid", dvalid, 0);
    chk("rst_r_en", r_en, 0);
    chk("rst_dout", dout, 0);
    chk("rst_pkt_len", pkt_len, 0);
    @(negedge rclk);
    rrst_n = 1'b1;

    // Four-word packet, consumer always ready
    for (int i = 0; i < 4; i++) push(32'h11 + 32'(i), i == 3);
    repeat (7) cyc(1'b1);
    #1;
    chk("len4", pkt_len, 4);
    @(negedge rclk);

    // Stalled consumer: two pops fill the stage, then the FIFO is left alone
    for (int i = 0; i < 3; i++) push($urandom, i == 2);
    repeat (5) cyc(1'b0);
    #1;
    chk("stall_r_en", r_en, 0);
    chk("stall_rempty", rempty, 0);
    @(negedge rclk);
    repeat (5) cyc(1'b1);

    // Alternating ready over 16 words
    for (int i = 0; i < 16; i++) push($urandom, (i == 7) || (i == 15));
    for (int i = 0; i < 40; i++) cyc(i[0] == 1'b0);

    // Back-to-back single-beat packets
    for (int i = 0; i < 3; i++) push($urandom, 1'b1);
    repeat (6) cyc(1'b1);

    // 15-beat packet (legal) then 17-beat packet (overflow)
    for (int i = 0; i < 15; i++) push($urandom, i == 14);
    repeat (18) cyc(1'b1);
    #1;
    chk("len15", pkt_len, 15);
    chk("no_ovf", len_ovf, 0);
    @(negedge rclk);
    for (int i = 0; i < 17; i++) push($urandom, i == 16);
    repeat (20) cyc(1'b1);
    #1;
    chk("len_sat", pkt_len, 15);
    chk("ovf_set", len_ovf, 1);
    @(negedge rclk);

    // Random traffic
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 1) == 1) push($urandom, $urandom_range(0, 3) == 0);
      cyc($urandom_range(0, 2) != 0);
    end
    push($urandom, 1'b1);
    repeat (40) cyc(1'b1);
    #1;
    chk("drained", dvalid, 0);
    chk("ovf_sticky", len_ovf, 1);
    @(negedge rclk);

    // Reset while both registers are loaded
    for (int i = 0; i < 4; i++) push($urandom, i == 3);
    repeat (3) cyc(1'b0);
    rrst_n = 1'b0;
    fifo_q.delete();
    rempty = 1'b1;
    rdata  = '0;
    #1;
    chk("mrst_dvalid", dvalid, 0);
    chk("mrst_r_en", r_en, 0);
    chk("mrst_dout", dout, 0);
    chk("mrst_dlast", dlast, 0);
    chk("mrst_pkt_len", pkt_len, 0);
    chk("mrst_pkt_done", pkt_done, 0);
    chk("mrst_len_ovf", len_ovf, 0);
    model_reset();
    @(negedge rclk);
    rrst_n = 1'b1;
    push(32'hA5A5_0001, 1'b0);
    push(32'hA5A5_0002, 1'b1);
    repeat (5) cyc(1'b1);
    #1;
    chk("post_rst_len", pkt_len, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
